// File: rtl/noc_data_to_ctrl.sv
// Wide data-NoC to narrow control-NoC message converter (header split + body serialisation).
// Define NOC_DATA_TO_CTRL_PREFETCH_EN to overlap the next body-flit load with the last slice.

`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 512
`endif
`ifndef CTRL_NOC1_DATA_W
`define CTRL_NOC1_DATA_W 64
`endif
`ifndef MSG_LENGTH_WIDTH
`define MSG_LENGTH_WIDTH 8
`endif
`ifndef MSG_LENGTH_LO
`define MSG_LENGTH_LO 22
`endif
`ifndef MSG_METADATA_FLITS_WIDTH
`define MSG_METADATA_FLITS_WIDTH 8
`endif
`ifndef MSG_METADATA_FLITS_LO
`define MSG_METADATA_FLITS_LO 0
`endif

module noc_data_to_ctrl (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         src_noc_dtc_val,
    input  logic [`NOC_DATA_WIDTH-1:0]   src_noc_dtc_data,
    output logic                         noc_dtc_src_rdy,
    output logic                         noc_dtc_dst_val,
    output logic [`CTRL_NOC1_DATA_W-1:0] noc_dtc_dst_data,
    input  logic                         dst_noc_dtc_rdy
);
    localparam int unsigned DataW          = `NOC_DATA_WIDTH;
    localparam int unsigned CtrlW          = `CTRL_NOC1_DATA_W;
    localparam int unsigned LenW           = `MSG_LENGTH_WIDTH;
    localparam int unsigned LenLo          = `MSG_LENGTH_LO;
    localparam int unsigned MetaW          = `MSG_METADATA_FLITS_WIDTH;
    localparam int unsigned MetaLo         = `MSG_METADATA_FLITS_LO;
    localparam int unsigned FLIT_MULTIPLES = DataW / CtrlW;
    localparam int unsigned FLIT_SHIFT     = $clog2(FLIT_MULTIPLES);

    typedef enum logic [2:0] {
        StReady,
        StHdr1Out,
        StHdr2Out,
        StBodyLoad,
        StBodyOut
    } state_e;

    state_e                  state_q, state_d;
    logic [FLIT_SHIFT-1:0]   idx_q, idx_d;
    logic [LenW-1:0]         cnt_q, cnt_d;
    logic [2*CtrlW-1:0]      hdr_q;
    logic [DataW-1:0]        buf_q;
    logic                    hdr_load, buf_load;
    logic                    last_slice;
    logic [CtrlW-1:0]        routing_flit, misc_flit;

    assign last_slice   = (idx_q == FLIT_SHIFT'(FLIT_MULTIPLES - 1));
    assign routing_flit = hdr_q[2*CtrlW-1 -: CtrlW];
    assign misc_flit    = hdr_q[CtrlW-1:0];

    always_comb begin
        noc_dtc_src_rdy = (state_q == StReady) || (state_q == StBodyLoad);
`ifdef NOC_DATA_TO_CTRL_PREFETCH_EN
        if ((state_q == StBodyOut) && last_slice && (cnt_q > LenW'(1))) begin
            noc_dtc_src_rdy = dst_noc_dtc_rdy;
        end
`endif
    end

    always_comb begin
        noc_dtc_dst_val  = 1'b0;
        noc_dtc_dst_data = '0;
        unique case (state_q)
            StHdr1Out: begin
                noc_dtc_dst_val  = 1'b1;
                noc_dtc_dst_data = routing_flit;
                // Narrow length counts the extra misc header flit.
                noc_dtc_dst_data[LenLo +: LenW] =
                    (routing_flit[LenLo +: LenW] << FLIT_SHIFT) + LenW'(1);
            end
            StHdr2Out: begin
                noc_dtc_dst_val  = 1'b1;
                noc_dtc_dst_data = misc_flit;
                noc_dtc_dst_data[MetaLo +: MetaW] = misc_flit[MetaLo +: MetaW] << FLIT_SHIFT;
            end
            StBodyOut: begin
                noc_dtc_dst_val  = 1'b1;
                noc_dtc_dst_data = buf_q[DataW - 1 - idx_q * CtrlW -: CtrlW];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        hdr_load = 1'b0;
        buf_load = 1'b0;
        unique case (state_q)
            StReady: begin
                if (src_noc_dtc_val) begin
                    hdr_load = 1'b1;
                    cnt_d    = src_noc_dtc_data[DataW - CtrlW + LenLo +: LenW];
                    state_d  = StHdr1Out;
                end
            end
            StHdr1Out: if (dst_noc_dtc_rdy) state_d = StHdr2Out;
            StHdr2Out: begin
                if (dst_noc_dtc_rdy) state_d = (cnt_q == '0) ? StReady : StBodyLoad;
            end
            StBodyLoad: begin
                if (src_noc_dtc_val) begin
                    buf_load = 1'b1;
                    idx_d    = '0;
                    state_d  = StBodyOut;
                end
            end
            StBodyOut: begin
                if (dst_noc_dtc_rdy) begin
                    if (!last_slice) begin
                        idx_d = idx_q + FLIT_SHIFT'(1);
                    end else begin
                        cnt_d = cnt_q - LenW'(1);
                        idx_d = '0;
                        if (cnt_q == LenW'(1)) begin
                            state_d = StReady;
                        end else begin
                            state_d = StBodyLoad;
`ifdef NOC_DATA_TO_CTRL_PREFETCH_EN
                            if (src_noc_dtc_val) begin
                                buf_load = 1'b1;
                                state_d  = StBodyOut;
                            end
`endif
                        end
                    end
                end
            end
            default: state_d = StReady;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StReady;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Datapath holds no state that matters across reset.
    always_ff @(posedge clk) begin
        if (hdr_load) hdr_q <= src_noc_dtc_data[DataW-1 -: 2*CtrlW];
        if (buf_load) buf_q <= src_noc_dtc_data;
    end

endmodule

// File: tb/tb_noc_data_to_ctrl.sv
// Directed self-checking bench for noc_data_to_ctrl (512-bit wide, 64-bit narrow).

module tb_noc_data_to_ctrl;
    logic         clk = 1'b0;
    logic         rst;
    logic         src_val;
    logic [511:0] src_data;
    logic         src_rdy;
    logic         dst_val;
    logic [63:0]  dst_data;
    logic         dst_rdy;

    noc_data_to_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .src_noc_dtc_val  (src_val),
        .src_noc_dtc_data (src_data),
        .noc_dtc_src_rdy  (src_rdy),
        .noc_dtc_dst_val  (dst_val),
        .noc_dtc_dst_data (dst_data),
        .dst_noc_dtc_rdy  (dst_rdy)
    );

    always #5 clk = ~clk;

    logic [511:0] src_q[$];
    int           gap_q[$];
    int           gap_cnt;
    logic [63:0]  exp_q[$];
    logic [63:0]  obs_q[$];
    int           obs_cyc[$];
    int           acc_cyc[$];
    int           cyc;
    int           n_checks;
    int           n_fail;
    int           stall_viol;
    logic         prev_stall;
    logic [63:0]  prev_data;

`ifdef NOC_DATA_TO_CTRL_PREFETCH_EN
    localparam int LastOff = 19;
    localparam int GapOff  = 4;
`else
    localparam int LastOff = 20;
    localparam int GapOff  = 5;
`endif

    task automatic clear_all();
        src_q.delete(); gap_q.delete(); exp_q.delete(); obs_q.delete();
        obs_cyc.delete(); acc_cyc.delete();
        gap_cnt = 0;
    endtask

    task automatic push_flit(input logic [511:0] w, input int gap);
        if (src_q.size() == 0) gap_cnt = gap;
        src_q.push_back(w);
        gap_q.push_back(gap);
    endtask

    // Reference model: build one wide message and its expected narrow stream.
    task automatic gen_msg(input int len, input int meta, input int gap);
        logic [511:0] w;
        logic [63:0]  f;
        for (int i = 0; i < 16; i++) w[32*i +: 32] = $urandom;
        w[470 +: 8] = 8'(len);
        w[384 +: 8] = 8'(meta);
        push_flit(w, 0);
        f = w[511:448];
        f[22 +: 8] = 8'((len << 3) + 1);
        exp_q.push_back(f);
        f = w[447:384];
        f[0 +: 8] = 8'(meta << 3);
        exp_q.push_back(f);
        for (int b = 0; b < len; b++) begin
            for (int i = 0; i < 16; i++) w[32*i +: 32] = $urandom;
            push_flit(w, gap);
            for (int k = 0; k < 8; k++) exp_q.push_back(w[511 - 64*k -: 64]);
        end
    endtask

    task automatic step(input bit rdy);
        logic [511:0] tmp_w;
        int           tmp_g;
        @(negedge clk);
        dst_rdy = rdy;
        src_val = (src_q.size() > 0) && (gap_cnt == 0);
        if (src_q.size() > 0) src_data = src_q[0];
        #1;
        cyc++;
        if (prev_stall && (dst_val !== 1'b1 || dst_data !== prev_data)) stall_viol++;
        prev_stall = dst_val && !dst_rdy;
        prev_data  = dst_data;
        if (dst_val && dst_rdy) begin
            obs_q.push_back(dst_data);
            obs_cyc.push_back(cyc);
        end
        if (src_val && src_rdy) begin
            acc_cyc.push_back(cyc);
            tmp_w   = src_q.pop_front();
            tmp_g   = gap_q.pop_front();
            gap_cnt = (gap_q.size() > 0) ? gap_q[0] : 0;
        end else if (src_q.size() > 0 && !src_val && src_rdy && gap_cnt > 0) begin
            gap_cnt--;
        end
    endtask

    task automatic run_until(input int n, input int budget, input bit rnd);
        int k = 0;
        while (obs_q.size() < n && k < budget) begin
            step(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            k++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; src_val = 1'b0; dst_rdy = 1'b0; src_data = '0;
        cyc = 0; prev_stall = 1'b0; prev_data = '0; gap_cnt = 0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (dst_val !== 1'b0) begin n_fail++; $display("FAIL reset_dst_val: got %b expected 0", dst_val); end
        n_checks++;
        if (src_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_src_rdy: got %b expected 1", src_rdy); end
        rst = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (dst_val !== 1'b0) begin n_fail++; $display("FAIL idle_dst_val: got %b expected 0", dst_val); end
        n_checks++;
        if (src_rdy !== 1'b1) begin n_fail++; $display("FAIL idle_src_rdy: got %b expected 1", src_rdy); end
    endtask

    task automatic test_header_only();
        int n;
        clear_all();
        gen_msg(0, 0, 0);
        gen_msg(0, 0, 0);
        run_until(4, 40, 1'b0);
        n_checks++;
        if (obs_q.size() != 4) begin n_fail++; $display("FAIL hdr_only_count: got %0d expected 4", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL hdr_only_flit%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        if (obs_q.size() == 4 && acc_cyc.size() == 2) begin
            n_checks++;
            if (obs_q[0][29:22] !== 8'd1) begin n_fail++; $display("FAIL hdr_only_len: got %0d expected 1", obs_q[0][29:22]); end
            n_checks++;
            if (obs_q[1][7:0] !== 8'd0) begin n_fail++; $display("FAIL hdr_only_meta: got %0d expected 0", obs_q[1][7:0]); end
            n_checks++;
            if (obs_cyc[0] - acc_cyc[0] != 1) begin n_fail++; $display("FAIL hdr1_latency: got %0d expected 1", obs_cyc[0] - acc_cyc[0]); end
            n_checks++;
            if (obs_cyc[1] - acc_cyc[0] != 2) begin n_fail++; $display("FAIL hdr2_latency: got %0d expected 2", obs_cyc[1] - acc_cyc[0]); end
            n_checks++;
            if (acc_cyc[1] - acc_cyc[0] != 3) begin n_fail++; $display("FAIL hdr_only_ready: got %0d expected 3", acc_cyc[1] - acc_cyc[0]); end
        end
        n = obs_q.size();
        repeat (5) step(1'b1);
        n_checks++;
        if (obs_q.size() != n) begin n_fail++; $display("FAIL hdr_only_extra: got %0d expected %0d", obs_q.size(), n); end
    endtask

    task automatic test_two_body();
        clear_all();
        gen_msg(2, 1, 0);
        run_until(18, 60, 1'b0);
        n_checks++;
        if (obs_q.size() != 18) begin n_fail++; $display("FAIL two_body_count: got %0d expected 18", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL two_body_flit%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        if (obs_q.size() == 18) begin
            n_checks++;
            if (obs_q[0][29:22] !== 8'd17) begin n_fail++; $display("FAIL two_body_len: got %0d expected 17", obs_q[0][29:22]); end
            n_checks++;
            if (obs_q[1][7:0] !== 8'd8) begin n_fail++; $display("FAIL two_body_meta: got %0d expected 8", obs_q[1][7:0]); end
            n_checks++;
            if (obs_cyc[2] - acc_cyc[0] != 4) begin n_fail++; $display("FAIL first_body_cycle: got %0d expected 4", obs_cyc[2] - acc_cyc[0]); end
            n_checks++;
            if (obs_cyc[17] - acc_cyc[0] != LastOff) begin
                n_fail++; $display("FAIL last_flit_cycle: got %0d expected %0d", obs_cyc[17] - acc_cyc[0], LastOff);
            end
        end
    endtask

    task automatic test_backpressure();
        int errs = 0;
        clear_all();
        stall_viol = 0;
        for (int m = 0; m < 100; m++) gen_msg($urandom_range(0, 7), $urandom_range(0, 31), 0);
        run_until(exp_q.size(), 40000, 1'b1);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL bp_count: got %0d expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; errs++;
                if (errs <= 20) $display("FAIL bp_flit%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (stall_viol != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes expected 0", stall_viol); end
    endtask

    task automatic test_src_gaps();
        clear_all();
        gen_msg(3, 2, 3);
        run_until(26, 100, 1'b0);
        n_checks++;
        if (obs_q.size() != 26) begin n_fail++; $display("FAIL gaps_count: got %0d expected 26", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL gaps_flit%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        if (obs_q.size() == 26) begin
            n_checks++;
            if (obs_cyc[2] - acc_cyc[0] != 7) begin n_fail++; $display("FAIL gaps_first_body: got %0d expected 7", obs_cyc[2] - acc_cyc[0]); end
            n_checks++;
            if (obs_cyc[10] - obs_cyc[9] != GapOff) begin
                n_fail++; $display("FAIL gaps_between: got %0d expected %0d", obs_cyc[10] - obs_cyc[9], GapOff);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_all();
        gen_msg(2, 1, 0);
        run_until(5, 40, 1'b0);
        @(negedge clk);
        rst = 1'b1; src_val = 1'b0; dst_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b0; prev_stall = 1'b0;
        #1;
        n_checks++;
        if (dst_val !== 1'b0) begin n_fail++; $display("FAIL rst_mid_dst_val: got %b expected 0", dst_val); end
        n_checks++;
        if (src_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_src_rdy: got %b expected 1", src_rdy); end
        clear_all();
        gen_msg(1, 3, 0);
        run_until(10, 40, 1'b0);
        n_checks++;
        if (obs_q.size() != 10) begin n_fail++; $display("FAIL rst_mid_count: got %0d expected 10", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL rst_mid_flit%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_all();
        gen_msg(1, 2, 0);
        gen_msg(0, 5, 0);
        run_until(12, 60, 1'b0);
        n_checks++;
        if (obs_q.size() != 12) begin n_fail++; $display("FAIL b2b_count: got %0d expected 12", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL b2b_flit%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        if (obs_q.size() == 12 && acc_cyc.size() == 3) begin
            n_checks++;
            if (acc_cyc[2] != obs_cyc[9] + 1) begin
                n_fail++; $display("FAIL b2b_accept: got %0d expected %0d", acc_cyc[2], obs_cyc[9] + 1);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        stall_viol = 0;
        test_reset();
        test_header_only();
        test_two_body();
        test_backpressure();
        test_src_gaps();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
